// File: rtl/seg_pkg.sv
// Shared 7-segment constants and code-to-pattern lookup for the scan driver.
// Patterns are stored active-low: bit7 = DP, bits 6:0 = g..a.
package seg_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] CODE_DASH = 4'hA;

    // Codes above the dash render with no segments lit; DP is applied separately.
    function automatic logic [7:0] seg_lookup(input logic [3:0] code);
        logic [7:0] pattern;
        case (code)
            4'h0:      pattern = SEG_0;
            4'h1:      pattern = SEG_1;
            4'h2:      pattern = SEG_2;
            4'h3:      pattern = SEG_3;
            4'h4:      pattern = SEG_4;
            4'h5:      pattern = SEG_5;
            4'h6:      pattern = SEG_6;
            4'h7:      pattern = SEG_7;
            4'h8:      pattern = SEG_8;
            4'h9:      pattern = SEG_9;
            CODE_DASH: pattern = SEG_DASH;
            default:   pattern = SEG_OFF;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_scan_gen_decode.sv
// Combinational segment decoder: 4-bit code plus decimal point to an 8-bit
// pattern in the board polarity selected by ACTIVE_LOW.
module seg_decode
    import seg_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] code,
    input  logic       dp,
    output logic [7:0] pattern
);

    logic [7:0] raw;

    always_comb begin
        raw = seg_lookup(code);
        if (dp) begin
            raw[7] = 1'b0;
        end
        pattern = (ACTIVE_LOW != 0) ? raw : ~raw;
    end

endmodule

// File: rtl/seg_scan_gen.sv
// Multiplexed 7-segment scan driver with PWM brightness and frame-synchronous
// input shadowing. Optional leading-zero suppression under macro SEG_LZS_EN.
module seg_scan_gen
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  seg_clk,
    input  logic                  seg_rst,
    input  logic [4*DIGITS-1:0]   dsp_data,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [3:0]            bright,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_tick
);

    localparam int CW       = $clog2(SCAN_DIV);
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PWM_STEP = SCAN_DIV / 16;

    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [7:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]       cnt_reg;
    logic [IW-1:0]       idx_reg;
    logic                primed_reg;
    logic [4*DIGITS-1:0] data_reg;
    logic [DIGITS-1:0]   dp_reg;
    logic [DIGITS-1:0]   blank_reg;
    logic [3:0]          bright_reg;
    logic [7:0]          seg_reg;
    logic [DIGITS-1:0]   sel_reg;
    logic                frame_tick_reg;

    logic [3:0]          code_s [DIGITS];
    logic [DIGITS-1:0]   suppress;

    logic                load;
    logic [CW:0]         pwm_thr;
    logic                pwm_on;
    logic                lit;
    logic [DIGITS-1:0]   onehot;
    logic [7:0]          pattern;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   sel_next;

    // Digit 0 sits in the most significant nibble of the packed code bus.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign code_s[gi] = data_reg[4*(DIGITS-gi)-1 -: 4];
`ifdef SEG_LZS_EN
            if (gi == DIGITS - 1) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_lead
                logic [gi:0] zero_run;
                for (genvar gj = 0; gj <= gi; gj++) begin : g_run
                    assign zero_run[gj] = (code_s[gj] == 4'h0) && !dp_reg[gj];
                end
                assign suppress[gi] = &zero_run;
            end
`else
            assign suppress[gi] = 1'b0;
`endif
        end
    endgenerate

    assign load = !primed_reg || ((cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST));

    // Threshold can equal SCAN_DIV at full brightness, hence one extra bit.
    assign pwm_thr = (CW+1)'((int'(bright_reg) + 1) * PWM_STEP);
    assign pwm_on  = (bright_reg == 4'hF) || ({1'b0, cnt_reg} < pwm_thr);
    assign lit     = pwm_on && !blank_reg[idx_reg] && !suppress[idx_reg];
    assign onehot  = DIGITS'(1) << idx_reg;

    seg_decode #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_decode (
        .code    (code_s[idx_reg]),
        .dp      (dp_reg[idx_reg]),
        .pattern (pattern)
    );

    always_comb begin
        seg_next = SEG_IDLE;
        sel_next = SEL_IDLE;
        if (lit) begin
            seg_next = pattern;
            sel_next = (ACTIVE_LOW != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge seg_clk or posedge seg_rst) begin
        if (seg_rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            primed_reg     <= 1'b0;
            data_reg       <= '0;
            dp_reg         <= '0;
            blank_reg      <= '0;
            bright_reg     <= '0;
            seg_reg        <= SEG_IDLE;
            sel_reg        <= SEL_IDLE;
            frame_tick_reg <= 1'b0;
        end else begin
            if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (load) begin
                primed_reg <= 1'b1;
                data_reg   <= dsp_data;
                dp_reg     <= dp_en;
                blank_reg  <= blank_mask;
                bright_reg <= bright;
            end

            frame_tick_reg <= load;
            seg_reg        <= seg_next;
            sel_reg        <= sel_next;
        end
    end

    assign seg        = seg_reg;
    assign sel        = sel_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_gen.sv
// Directed self-checking bench for seg_scan_gen (DIGITS=4, SCAN_DIV=32,
// active-low). Expected frames are derived from hand-computed segment tables.
module tb_seg_scan_gen;

    logic        clk;
    logic        rst;
    logic [15:0] dsp_data;
    logic [3:0]  dp_en;
    logic [3:0]  blank_mask;
    logic [3:0]  bright;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    seg_scan_gen #(
        .DIGITS     (4),
        .SCAN_DIV   (32),
        .ACTIVE_LOW (1)
    ) dut (
        .seg_clk    (clk),
        .seg_rst    (rst),
        .dsp_data   (dsp_data),
        .dp_en      (dp_en),
        .blank_mask (blank_mask),
        .bright     (bright),
        .seg        (seg),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, j, obs, exp);
        end
    endtask

    // Walks one frame (4 slots x 32 cycles) sampling on the falling edge.
    // Sample j shows the registered result of frame cycle j; chg is
    // {dp_en, dsp_data} applied right after sample chg_j (-1: none).
    task automatic check_frame(input string tag, input logic [31:0] segs, input logic [3:0] dark,
                               input int lvl, input int start_j, input int chg_j, input logic [19:0] chg);
        int d;
        int c;
        bit lit;
        logic [7:0] eseg;
        logic [3:0] esel;
        int fails0;
        fails0 = failures;
        for (int j = start_j; j < 128; j++) begin
            @(negedge clk);
            d    = j / 32;
            c    = j % 32;
            lit  = ((lvl == 15) || (c < (lvl + 1) * 2)) && !dark[d];
            esel = lit ? ~(4'b0001 << d) : 4'hF;
            eseg = lit ? segs[31-8*d -: 8] : 8'hFF;
            chk({tag, " sel"}, j, 32'(sel), 32'(esel));
            chk({tag, " seg"}, j, 32'(seg), 32'(eseg));
            chk({tag, " tick"}, j, 32'(frame_tick), (j == 127) ? 32'd1 : 32'd0);
            if (j == chg_j) begin
                {dp_en, dsp_data} = chg;
            end
        end
        $display("frame %-22s start=%0d new_errors=%0d", tag, start_j, failures - fails0);
    endtask

    initial begin
        logic [3:0] lzs_dark;
`ifdef SEG_LZS_EN
        lzs_dark = 4'b0111;
`else
        lzs_dark = 4'b0000;
`endif
        rst        = 1'b1;
        dsp_data   = 16'h1234;
        dp_en      = 4'b0000;
        blank_mask = 4'b0000;
        bright     = 4'd15;

        // Reset state while clock runs.
        repeat (3) @(negedge clk);
        chk("reset seg", 0, 32'(seg), 32'hFF);
        chk("reset sel", 0, 32'(sel), 32'hF);
        chk("reset tick", 0, 32'(frame_tick), 32'h0);
        rst = 1'b0;

        // Test 1: first cycle is the priming load, then 1234 at full brightness.
        @(negedge clk);
        chk("prime tick", 0, 32'(frame_tick), 32'h1);
        check_frame("t1 1234 full", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000, 15, 1, -1, 20'h0);
        check_frame("t1 1234 period", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000, 15, 0, -1, 20'h0);

        // Test 2: brightness change waits for the next frame load.
        bright = 4'd3;
        check_frame("t2 bright pending", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000, 15, 0, -1, 20'h0);
        check_frame("t2 bright 3", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000, 3, 0, -1, 20'h0);

        // Test 3: dash, zero with DP, blank codes, then a blanked digit.
        dsp_data = 16'hA0BF;
        dp_en    = 4'b0010;
        bright   = 4'd15;
        check_frame("t3 old", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'b0000, 3, 0, -1, 20'h0);
        blank_mask = 4'b0100;
        check_frame("t3 A0BF dp", {8'hBF, 8'h40, 8'hFF, 8'hFF}, 4'b0000, 15, 0, -1, 20'h0);
        blank_mask = 4'b0000;
        dp_en      = 4'b0000;
        dsp_data   = 16'h1111;
        check_frame("t3 blank digit2", {8'hBF, 8'h40, 8'hFF, 8'hFF}, 4'b0100, 15, 0, -1, 20'h0);

        // Test 4: mid-frame data change is held off until the frame load.
        check_frame("t4 1111 chg 2222", {8'hF9, 8'hF9, 8'hF9, 8'hF9}, 4'b0000, 15, 0, 40, {4'b0000, 16'h2222});
        dsp_data = 16'h0007;
        check_frame("t4 2222", {8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'b0000, 15, 0, -1, 20'h0);

        // Test 5: leading zeros (suppressed only when the feature is built in).
        check_frame("t5 0007", {8'hC0, 8'hC0, 8'hC0, 8'hF8}, lzs_dark, 15, 0, 10, {4'b0000, 16'h0000});
        check_frame("t5 0000", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, lzs_dark, 15, 0, 10, {4'b0001, 16'h0050});
        check_frame("t5 0050 dp0", {8'h40, 8'hC0, 8'h92, 8'hC0}, 4'b0000, 15, 0, -1, 20'h0);

        // Test 6: asynchronous reset mid-slot, then a clean restart.
        repeat (45) @(negedge clk);
        chk("pre-reset sel", 44, 32'(sel), 32'hD);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset seg", 0, 32'(seg), 32'hFF);
        chk("async reset sel", 0, 32'(sel), 32'hF);
        chk("async reset tick", 0, 32'(frame_tick), 32'h0);
        dsp_data = 16'h8888;
        dp_en    = 4'b0000;
        repeat (2) @(negedge clk);
        chk("held reset sel", 0, 32'(sel), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("restart tick", 0, 32'(frame_tick), 32'h1);
        check_frame("t6 restart 8888", {8'h80, 8'h80, 8'h80, 8'h80}, 4'b0000, 15, 1, -1, 20'h0);

        // Minimum brightness: on for one PWM step per slot.
        bright = 4'd0;
        check_frame("t7 bright pending", {8'h80, 8'h80, 8'h80, 8'h80}, 4'b0000, 15, 0, -1, 20'h0);
        check_frame("t7 bright 0", {8'h80, 8'h80, 8'h80, 8'h80}, 4'b0000, 0, 0, -1, 20'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
